// File: rtl/cpu8_pkg.sv
// cpu8_pkg: opcodes, sequencer states and datapath select encodings for the 8-bit CPU.
package cpu8_pkg;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVRA = 4'b1000;
   localparam logic [3:0] OP_MVAR = 4'b1001;
   localparam logic [3:0] OP_BNE  = 4'b1010;
   localparam logic [3:0] OP_BLTZ = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_J    = 4'b1110;
   localparam logic [3:0] OP_JAL  = 4'b1111;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_RD2 = 2'b10;
   localparam logic [1:0] WB_PC  = 2'b11;

   function automatic logic is_alu(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_SHL, OP_SHR};
   endfunction

   // movs pass through as add; bne compares by subtracting
   function automatic logic [3:0] alu_ctl(input logic [3:0] op);
      return (is_alu(op) || op == OP_LD || op == OP_ST || op == OP_BLTZ) ? op :
             (op == OP_BNE) ? OP_SUB : OP_ADD;
   endfunction
endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: counts stalled memory request cycles; flags the cycle that exhausts TIMEOUT.
module seq_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + 1'b1;
   assign o_expired = i_inc && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb control FSM for the 8-bit accumulator CPU.
module multicycle_sequencer
   import cpu8_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   input  logic       mem_ready,
   input  logic [7:0] mem_rdata,
   input  logic       alu_zero,
   input  logic       alu_neg,
   output logic [1:0] reg_addr1,
   output logic [1:0] reg_addr2,
   output logic [3:0] alu_control,
   output logic       rf_we,
   output logic [1:0] rf_waddr,
   output logic [1:0] wb_src,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       retire,
   output logic       fault
);
   state_t     r_state, w_next;
   logic [7:0] r_ir;
   logic [3:0] w_op;
   logic       w_expired;

   assign w_op      = r_ir[7:4];
   assign reg_addr1 = r_ir[3:2];
   assign reg_addr2 = r_ir[1:0];
   assign fault     = (r_state == S_FAULT);

   seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_inc     (mem_req & ~mem_ready),
      .i_clr     (mem_req & mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && mem_ready) r_ir <= mem_rdata;
      end

   always_comb begin
      w_next      = r_state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      alu_control = 4'b0000;
      rf_we       = 1'b0;
      rf_waddr    = 2'b00;
      wb_src      = WB_ALU;
      pc_we       = 1'b0;
      pc_src      = PC_INC;
      retire      = 1'b0;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            pc_we   = mem_ready;
            w_next  = mem_ready ? S_DECODE : w_expired ? S_FAULT : S_FETCH;
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            alu_control = alu_ctl(w_op);
            w_next = (is_alu(w_op) || w_op == OP_MVRA || w_op == OP_MVAR) ? S_WB :
                     (w_op == OP_LD || w_op == OP_ST) ? S_MEM : S_FETCH;
            retire = (w_next == S_FETCH);
            pc_we  = (w_op == OP_BNE && !alu_zero) || (w_op == OP_BLTZ && alu_neg) ||
                     w_op == OP_J || w_op == OP_JAL;
            pc_src = !pc_we ? PC_INC : (w_op[3:1] == 3'b111) ? PC_JMP : PC_BR;
            // jal links the already-incremented PC in the same cycle as the jump
            rf_we    = (w_op == OP_JAL);
            rf_waddr = (w_op == OP_JAL) ? 2'b11 : 2'b00;
            wb_src   = (w_op == OP_JAL) ? WB_PC : WB_ALU;
         end
         S_MEM: begin
            alu_control = alu_ctl(w_op);
            mem_req     = 1'b1;
            addr_sel    = 1'b1;
            mem_we      = (w_op == OP_ST);
            retire      = mem_ready && (w_op == OP_ST);
            w_next      = !mem_ready ? (w_expired ? S_FAULT : S_MEM) :
                          (w_op == OP_ST) ? S_FETCH : S_WB;
         end
         S_WB: begin
            alu_control = alu_ctl(w_op);
            rf_we       = 1'b1;
            retire      = 1'b1;
            rf_waddr    = (w_op == OP_MVRA) ? 2'b00 : (w_op == OP_MVAR) ? r_ir[1:0] : r_ir[3:2];
            wb_src      = (w_op == OP_LD) ? WB_MEM : (w_op == OP_MVRA) ? WB_RD2 : WB_ALU;
            w_next      = S_FETCH;
         end
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed instruction sequences with hand-computed control vectors.
module tb_multicycle_sequencer;
   logic       clk = 1'b0, reset = 1'b1, mem_ready = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_req, mem_we, addr_sel, rf_we, pc_we, retire, fault;
   logic [1:0] reg_addr1, reg_addr2, rf_waddr, wb_src, pc_src;
   logic [3:0] alu_control;
   int         checks = 0, failures = 0;

   multicycle_sequencer #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .alu_control(alu_control), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .wb_src(wb_src), .pc_we(pc_we), .pc_src(pc_src), .retire(retire),
      .fault(fault)
   );

   always #5 clk = ~clk;

   // control vector: req we asel | rf_we waddr wb_src | pc_we pc_src | retire fault
   localparam logic [12:0] V_ZERO = 13'b0_0_0_0_00_00_0_00_0_0;
   localparam logic [12:0] V_FR   = 13'b1_0_0_0_00_00_1_00_0_0;
   localparam logic [12:0] V_FW   = 13'b1_0_0_0_00_00_0_00_0_0;
   localparam logic [12:0] V_ADDW = 13'b0_0_0_1_01_00_0_00_1_0;
   localparam logic [12:0] V_LDM  = 13'b1_0_1_0_00_00_0_00_0_0;
   localparam logic [12:0] V_LDW  = 13'b0_0_0_1_10_01_0_00_1_0;
   localparam logic [12:0] V_BT   = 13'b0_0_0_0_00_00_1_01_1_0;
   localparam logic [12:0] V_BN   = 13'b0_0_0_0_00_00_0_00_1_0;
   localparam logic [12:0] V_JAL  = 13'b0_0_0_1_11_11_1_10_1_0;
   localparam logic [12:0] V_MVW  = 13'b0_0_0_1_10_00_0_00_1_0;
   localparam logic [12:0] V_STM  = 13'b1_1_1_0_00_00_0_00_0_0;
   localparam logic [12:0] V_FLT  = 13'b0_0_0_0_00_00_0_00_0_1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [12:0] e);
      #1;
      chk(tag, {3'b0, mem_req, mem_we, addr_sel, rf_we, rf_waddr, wb_src, pc_we, pc_src, retire, fault},
          {3'b0, e});
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      step("reset_ctl", V_ZERO);
      chk("reset_ir", {8'h0, reg_addr1, reg_addr2, alu_control}, 16'h0);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h06;
      step("idle", V_ZERO); cyc;
      // add r1,r2 with zero-wait memory
      step("add_fetch", V_FR); cyc;
      step("add_decode", V_ZERO);
      chk("add_regs", {12'h0, reg_addr1, reg_addr2}, 16'h0006); cyc;
      step("add_exec", V_ZERO);
      chk("add_alu", {12'h0, alu_control}, 16'h0000); cyc;
      mem_rdata = 8'h4B;
      step("add_wb", V_ADDW); cyc;
      // load with three wait cycles
      step("ld_fetch", V_FR); cyc;
      step("ld_decode", V_ZERO);
      chk("ld_regs", {12'h0, reg_addr1, reg_addr2}, 16'h000B); cyc;
      step("ld_exec", V_ZERO);
      chk("ld_alu", {12'h0, alu_control}, 16'h0004);
      mem_ready = 1'b0; cyc;
      for (int i = 0; i < 3; i++) begin step("ld_mem_wait", V_LDM); cyc; end
      mem_ready = 1'b1;
      step("ld_mem_done", V_LDM); cyc;
      mem_rdata = 8'hA1;
      step("ld_wb", V_LDW); cyc;
      // bne taken
      step("bne_t_fetch", V_FR); cyc;
      step("bne_t_decode", V_ZERO); cyc;
      alu_zero = 1'b0;
      step("bne_t_exec", V_BT);
      chk("bne_alu", {12'h0, alu_control}, 16'h0001); cyc;
      // bne not taken
      step("bne_n_fetch", V_FR); cyc;
      step("bne_n_decode", V_ZERO); cyc;
      alu_zero = 1'b1; mem_rdata = 8'hF2;
      step("bne_n_exec", V_BN); cyc;
      // jal
      step("jal_fetch", V_FR); cyc;
      step("jal_decode", V_ZERO); cyc;
      mem_rdata = 8'h9E;
      step("jal_exec", V_JAL); cyc;
      // mov Acc->R2
      step("mov_fetch", V_FR); cyc;
      step("mov_decode", V_ZERO); cyc;
      step("mov_exec", V_ZERO); cyc;
      mem_rdata = 8'h56;
      step("mov_wb", V_MVW);
      chk("mov_alu", {12'h0, alu_control}, 16'h0000); cyc;
      // store interrupted by reset while waiting in MEM
      step("st_fetch", V_FR); cyc;
      step("st_decode", V_ZERO); cyc;
      step("st_exec", V_ZERO);
      chk("st_alu", {12'h0, alu_control}, 16'h0005);
      mem_ready = 1'b0; cyc;
      step("st_mem_wait", V_STM); cyc;
      #3 reset = 1'b1;
      #2;
      chk("st_async_reset", {3'b0, mem_req, mem_we, addr_sel, rf_we, rf_waddr, wb_src, pc_we, pc_src,
          retire, fault}, {3'b0, V_ZERO});
      chk("st_reset_ir", {12'h0, reg_addr1, reg_addr2}, 16'h0000);
      @(negedge clk);
      reset = 1'b0; mem_rdata = 8'h06;
      step("post_rst_idle", V_ZERO); cyc;
      // ready on the last permitted wait cycle still completes the fetch
      for (int i = 0; i < 15; i++) begin step("fetch_wait", V_FW); cyc; end
      mem_ready = 1'b1;
      step("ready_wins", V_FR); cyc;
      step("ready_wins_decode", V_ZERO); cyc;
      step("rw_exec", V_ZERO); cyc;
      mem_ready = 1'b0;
      step("rw_wb", V_ADDW); cyc;
      // timeout after 16 stalled request cycles
      for (int i = 0; i < 16; i++) begin step("to_wait", V_FW); cyc; end
      step("to_fault", V_FLT); cyc;
      mem_ready = 1'b1;
      step("to_fault_sticky", V_FLT); cyc;
      reset = 1'b1;
      step("to_reset", V_ZERO);
      @(negedge clk);
      reset = 1'b0;
      step("to_idle", V_ZERO); cyc;
      step("to_refetch", V_FR);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the 8-bit accumulator/register CPU. It fetches one 8-bit instruction per pass over a single shared memory port with a req/ready handshake, holds it in an internal IR, and sequences the existing ALU, register file and PC through decode, execute, memory and write-back. It sits between instruction/data memory and the datapath, and replaces per-instruction single-cycle decode.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles a memory request may wait for mem_ready before FAULT; range 2..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write (store); valid only while mem_req=1.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- mem_ready  in  1  transfer completes in a cycle where mem_req=1 and mem_ready=1.
- mem_rdata  in  8  fetched instruction, captured into IR on fetch completion.
- alu_zero, alu_neg  in  1 each  ALU flags, sampled in EXEC.
- reg_addr1, reg_addr2  out  2 each  IR[3:2], IR[1:0].
- alu_control  out  4  ALU operation.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  2  write address.
- wb_src  out  2  write data: 00 ALU, 01 memory, 10 register read port 2, 11 PC.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- fault  out  1  sticky memory-timeout indication.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Reset forces IDLE; IDLE goes to FETCH unconditionally.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. When mem_ready=1, load IR, pulse pc_we with pc_src=00, and go to DECODE.
- DECODE: drive reg_addr1/2 from IR; go to EXEC.
- EXEC, ALU ops (0000 add, 0001 sub, 0010 and, 0011 nor, 1100 shl, 1101 shr): alu_control = opcode; go to WB.
- EXEC, load (0100) and store (0101): alu_control = opcode; go to MEM.
- EXEC, mov R->Acc (1000) and mov Acc->R (1001): alu_control = 0000; go to WB.
- EXEC, bne (1010): alu_control = 0001. If alu_zero=0, pc_we=1 with pc_src=01. Retire; go to FETCH.
- EXEC, bltz (1011): alu_control = 1011. If alu_neg=1, pc_we=1 with pc_src=01. Retire; go to FETCH.
- EXEC, j (1110): pc_we=1, pc_src=10. Retire; go to FETCH.
- EXEC, jal (1111): pc_we=1, pc_src=10, plus rf_we=1, rf_waddr=11, wb_src=11. Link = already-incremented PC, read before the update. Retire; go to FETCH.
- EXEC, undefined opcodes (0110, 0111): NOP. Retire; go to FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we = (opcode==0101). On mem_ready, load goes to WB; store retires and goes to FETCH.
- WB: rf_we=1, then retire.
  - ALU ops: rf_waddr=IR[3:2], wb_src=00.
  - load: rf_waddr=IR[3:2], wb_src=01.
  - 1000: rf_waddr=00, wb_src=10.
  - 1001: rf_waddr=IR[1:0], wb_src=00 (ALU passes Acc).
- Wait timer: counts cycles with mem_req=1 and mem_ready=0, and clears on any completion. If it reaches TIMEOUT, go to FAULT.
- FAULT: all strobes low, fault=1. Exit only by reset.

## Timing
- Reset value of every output is 0; the IDLE state also drives all outputs 0. The first mem_req appears in the second cycle after reset deasserts.
- All outputs are decoded from state and IR only, except pc_we/pc_src in EXEC (flag-dependent) and the completion strobes (ready-dependent).
- While waiting, mem_req, mem_we and addr_sel stay stable until completion. mem_ready is ignored when mem_req=0.
- Latency with zero-wait memory (ready in the request cycle):
  - ALU/mov: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch/jump/NOP: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout: FAULT is entered on the edge after TIMEOUT consecutive non-ready request cycles. Ready arriving in that same cycle wins over the timeout.
- Reset asserted mid-instruction clears IR, the timer and fault; any in-flight request is dropped.

## Structure
- Package cpu8_pkg holds: opcode constants, the state enum, and the pc_src and wb_src encodings.
- One sub-module, seq_wait_timer: counter, clear, and expired output, sized by TIMEOUT.

## Test plan
- Zero-wait add: IR=0x06, ready tied high. Expect rf_we in cycle 4, rf_waddr=01, wb_src=00, alu_control=0000, retire coincident with rf_we.
- Load with 3 wait cycles: IR=0x4B. Expect MEM to hold mem_req=1, addr_sel=1, mem_we=0 for 4 cycles, then WB with rf_waddr=10, wb_src=01; total 8 cycles.
- bne: IR=0xA1, once with alu_zero=0 and once with alu_zero=1.
  - alu_zero=0: pc_we=1, pc_src=01 in EXEC.
  - alu_zero=1: no pc_we in EXEC.
  - Both cases: retire in cycle 3.
- jal: IR=0xF2. Expect, in the same cycle, pc_src=10, pc_we=1, rf_we=1, rf_waddr=11, wb_src=11.
- Timeout: mem_ready held 0 with TIMEOUT=16. Expect fault=1 after 16 request cycles and no further mem_req. Reset clears fault and restarts at IDLE.
- Reset mid-MEM of a store: mem_req and mem_we drop to 0 asynchronously; after release, fetch resumes with addr_sel=0.
